// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: constants and bundle types for the in-order RISC-V pipeline.
// The IF/ID bundle defined here is what the decode/control stage consumes.
package rv_pipe_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    // addi x0,x0,0: the canonical bubble, decodes to an all-zero control word
    localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } ifid_t;

    localparam ifid_t IFID_RESET = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};

    // Instructions are word aligned; low address bits of a target are dropped.
    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {pc, instr} holding register. Catches the fetch
// that was in flight when a stall arrived so it is not lost. Clear wins over load.
module fetch_skid_buf
    import rv_pipe_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;

    // Capture on load, drop on clear; payload is only meaningful while valid.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_instr <= i_instr;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_instr = r_instr;

endmodule

// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: IF stage plus IF/ID register. Owns the PC, drives the
// synchronous instruction memory, absorbs stalls with a one-entry skid and
// turns EX redirects into a two-bubble flush.
// Optional: define FETCH_PERF_EN to build the saturating fetch/bubble counters;
// otherwise the counter outputs are tied to zero.
module fetch_ifid_stage
    import rv_pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_redirect,
    input  logic [XLEN-1:0]  i_redirect_pc,
    output logic             o_imem_en,
    output logic [XLEN-1:0]  o_imem_addr,
    input  logic [31:0]      i_imem_rdata,
    output logic             o_ifid_valid,
    output logic [XLEN-1:0]  o_ifid_pc,
    output logic [31:0]      o_ifid_instr,
    output logic [CNT_W-1:0] o_perf_fetch_cnt,
    output logic [CNT_W-1:0] o_perf_bubble_cnt
);

    logic [XLEN-1:0] r_pc;
    logic            r_fValid;
    logic [XLEN-1:0] r_fPc;
    ifid_t           r_ifid;

    logic            w_skidLoad;
    logic            w_skidClear;
    logic            w_skidValid;
    logic [XLEN-1:0] w_skidPc;
    logic [31:0]     w_skidInstr;

    // No request goes out while stalled or flushing, so at most one fetch is
    // ever outstanding and a single skid entry is enough.
    assign o_imem_en   = !i_reset && !i_stall && !i_redirect;
    assign o_imem_addr = r_pc;

    assign w_skidLoad  = i_stall && !i_redirect && r_fValid;
    assign w_skidClear = i_redirect || (!i_stall && w_skidValid);

    fetch_skid_buf u_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_skidLoad),
        .i_clear (w_skidClear),
        .i_pc    (r_fPc),
        .i_instr (i_imem_rdata),
        .o_valid (w_skidValid),
        .o_pc    (w_skidPc),
        .o_instr (w_skidInstr)
    );

    // PC, in-flight tracking and IF/ID: redirect beats stall beats run.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc     <= RESET_PC;
            r_fValid <= 1'b0;
            r_fPc    <= '0;
            r_ifid   <= IFID_RESET;
        end else if (i_redirect) begin
            r_pc         <= alignPc(i_redirect_pc);
            r_fValid     <= 1'b0;
            r_ifid.valid <= 1'b0;
            r_ifid.instr <= NOP_INSTR;
        end else if (i_stall) begin
            r_fValid <= 1'b0;
        end else begin
            if (w_skidValid) begin
                r_ifid <= '{valid: 1'b1, pc: w_skidPc, instr: w_skidInstr};
            end else if (r_fValid) begin
                r_ifid <= '{valid: 1'b1, pc: r_fPc, instr: i_imem_rdata};
            end else begin
                r_ifid.valid <= 1'b0;
                r_ifid.instr <= NOP_INSTR;
            end
            r_fPc    <= r_pc;
            r_fValid <= 1'b1;
            r_pc     <= r_pc + XLEN'(4);
        end
    end

    assign o_ifid_valid = r_ifid.valid;
    assign o_ifid_pc    = r_ifid.pc;
    assign o_ifid_instr = r_ifid.instr;

`ifdef FETCH_PERF_EN
    logic             w_loadValid;
    logic             w_loadBubble;
    logic [CNT_W-1:0] r_perfFetch;
    logic [CNT_W-1:0] r_perfBubble;

    assign w_loadValid  = !i_redirect && !i_stall && (w_skidValid || r_fValid);
    assign w_loadBubble = i_redirect || (!i_stall && !w_skidValid && !r_fValid);

    // Saturating counts of real instructions and bubbles entering IF/ID.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_perfFetch  <= '0;
            r_perfBubble <= '0;
        end else begin
            if (w_loadValid && (r_perfFetch != '1)) begin
                r_perfFetch <= r_perfFetch + CNT_W'(1);
            end
            if (w_loadBubble && (r_perfBubble != '1)) begin
                r_perfBubble <= r_perfBubble + CNT_W'(1);
            end
        end
    end

    assign o_perf_fetch_cnt  = r_perfFetch;
    assign o_perf_bubble_cnt = r_perfBubble;
`else
    assign o_perf_fetch_cnt  = '0;
    assign o_perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// tb_fetch_ifid_stage: directed test of fetch_ifid_stage against a synchronous
// instruction memory whose word at byte address A is (A>>2)+1.
module tb_fetch_ifid_stage;
    import rv_pipe_pkg::*;

`ifdef FETCH_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             stall;
    logic             redirect;
    logic [XLEN-1:0]  redirectPc;
    logic             imemEn;
    logic [XLEN-1:0]  imemAddr;
    logic [31:0]      imemRdata;
    logic             ifidValid;
    logic [XLEN-1:0]  ifidPc;
    logic [31:0]      ifidInstr;
    logic [CNT_W-1:0] perfFetch;
    logic [CNT_W-1:0] perfBubble;

    int checks = 0;
    int errors = 0;

    fetch_ifid_stage dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_stall           (stall),
        .i_redirect        (redirect),
        .i_redirect_pc     (redirectPc),
        .o_imem_en         (imemEn),
        .o_imem_addr       (imemAddr),
        .i_imem_rdata      (imemRdata),
        .o_ifid_valid      (ifidValid),
        .o_ifid_pc         (ifidPc),
        .o_ifid_instr      (ifidInstr),
        .o_perf_fetch_cnt  (perfFetch),
        .o_perf_bubble_cnt (perfBubble)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [XLEN-1:0] addr);
        return (addr >> 2) + 32'd1;
    endfunction

    // Synchronous instruction memory: data appears the cycle after the request.
    always @(posedge clk) begin
        if (imemEn) imemRdata <= memWord(imemAddr);
    end

    // Backstop so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rd, input logic [XLEN-1:0] rpc);
        stall      = st;
        redirect   = rd;
        redirectPc = rpc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic v, input logic [XLEN-1:0] pc, input logic [31:0] instr);
        checkVal({tag, ".valid"}, 32'(ifidValid), 32'(v));
        checkVal({tag, ".pc"}, ifidPc, pc);
        checkVal({tag, ".instr"}, ifidInstr, instr);
    endtask

    task automatic checkFetch(input string tag, input logic en, input logic [XLEN-1:0] addr);
        checkVal({tag, ".imem_en"}, 32'(imemEn), 32'(en));
        checkVal({tag, ".imem_addr"}, imemAddr, addr);
    endtask

    task automatic checkPerf(input string tag, input int nFetch, input int nBubble);
        checkVal({tag, ".perf_fetch"}, perfFetch, PERF_ON ? 32'(nFetch) : 32'd0);
        checkVal({tag, ".perf_bubble"}, perfBubble, PERF_ON ? 32'(nBubble) : 32'd0);
    endtask

    // Directed sequence; expected values are worked out by hand from the memory pattern.
    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPc = '0;
        imemRdata  = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset", 1'b0, 32'h0, NOP_INSTR);
        checkFetch("reset", 1'b0, 32'h0);
        checkPerf("reset", 0, 0);
        reset = 1'b0;

        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("startup", 1'b0, 32'h0, NOP_INSTR);
        checkFetch("startup", 1'b1, 32'h4);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("run0", 1'b1, 32'h0, 32'd1);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("run4", 1'b1, 32'h4, 32'd2);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput("stallHold", 1'b1, 32'h4, 32'd2);
            checkFetch("stallHold", 1'b0, 32'hC);
        end
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("release8", 1'b1, 32'h8, 32'd3);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("releaseC", 1'b1, 32'hC, 32'd4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            checkOutput("runMid", 1'b1, 32'h10 + 32'(4 * i), 32'd5 + 32'(i));
        end
        checkFetch("atPc20", 1'b1, 32'h20);

        applyStimulus(1'b0, 1'b1, 32'h103);
        checkOutput("redirBubble1", 1'b0, 32'h18, NOP_INSTR);
        checkFetch("redirTarget", 1'b0, 32'h100);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("redirBubble2", 1'b0, 32'h18, NOP_INSTR);
        checkFetch("redirNext", 1'b1, 32'h104);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("target100", 1'b1, 32'h100, 32'h41);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("target104", 1'b1, 32'h104, 32'h42);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("target108", 1'b1, 32'h108, 32'h43);
        checkPerf("tenPlusRedirect", 10, 3);

        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("skidFill", 1'b1, 32'h108, 32'h43);
        applyStimulus(1'b1, 1'b1, 32'h200);
        checkOutput("redirStall1", 1'b0, 32'h108, NOP_INSTR);
        checkFetch("redirStall", 1'b0, 32'h200);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("skidDropped", 1'b0, 32'h108, NOP_INSTR);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("target200", 1'b1, 32'h200, 32'h81);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("target204", 1'b1, 32'h204, 32'h82);
        checkPerf("afterSkidFlush", 12, 5);

        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
        checkFetch("wrapStart", 1'b0, 32'hFFFF_FFF8);
        applyStimulus(1'b0, 1'b0, '0);
        checkFetch("wrapFFC", 1'b1, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, '0);
        checkFetch("wrapZero", 1'b1, 32'h0);
        checkOutput("wrapFF8", 1'b1, 32'hFFFF_FFF8, 32'h3FFF_FFFF);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("wrapFFCout", 1'b1, 32'hFFFF_FFFC, 32'h4000_0000);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("wrap0out", 1'b1, 32'h0, 32'd1);
        checkPerf("afterWrap", 15, 7);

        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("preResetStall", 1'b1, 32'h0, 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midStallReset", 1'b0, 32'h0, NOP_INSTR);
        checkFetch("midStallReset", 1'b0, 32'h0);
        checkPerf("midStallReset", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("restartBubble", 1'b0, 32'h0, NOP_INSTR);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("restart0", 1'b1, 32'h0, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
